// File: rtl/udp_stream_tx.sv
// -----------------------------------------------------------------------------
// udp_stream_tx
//
// Multi-channel UDP packetiser. Drains up to NUM_CH first-word-fall-through
// sample FIFOs into fixed-size UDP packets on the 32-bit UDP core write port.
// Channels are served round-robin. Each packet carries four header words, one
// info word ({channel, address tag}) and PAYLOAD_WORDS data words.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   cfg_we/addr/data config write: 0 = interval[23:0], 1 = enable mask,
//                    2 = destination IP, 3 = ignored
//   ch_level         per-channel FIFO fill level (LVL_W bits each)
//   ch_data          per-channel FIFO head word (32 bits each)
//   ch_tag           per-channel tag-FIFO head (28 bits each)
//   ch_rd            data pop, one-hot, same cycle the head word is used
//   ch_tag_rd        tag pop, one-hot, same cycle the tag is used
//   w_req / w_ack    transmit request / grant handshake with the UDP core
//   w_enable/w_data  registered write word stream
//   pkt_cnt          packets fully sent (wraps)
//   cur_ch           channel of the current or last packet
// -----------------------------------------------------------------------------
module udp_stream_tx #(
    parameter int          NUM_CH        = 2,
    parameter int          PAYLOAD_WORDS = 64,
    parameter int          LVL_W         = 12,
    parameter logic [31:0] SRC_IP        = 32'h0a000001,
    parameter logic [31:0] DST_IP_RST    = 32'h0a000003,
    parameter logic [31:0] PORTS         = 32'h40004000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [31:0]             cfg_data,
    input  logic [NUM_CH*LVL_W-1:0] ch_level,
    input  logic [NUM_CH*32-1:0]    ch_data,
    input  logic [NUM_CH*28-1:0]    ch_tag,
    output logic [NUM_CH-1:0]       ch_rd,
    output logic [NUM_CH-1:0]       ch_tag_rd,
    output logic                    w_req,
    input  logic                    w_ack,
    output logic                    w_enable,
    output logic [31:0]             w_data,
    output logic [31:0]             pkt_cnt,
    output logic [3:0]              cur_ch
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        HDR,
        INFO,
        PAY
    } state_t;

    localparam logic [LVL_W-1:0] PAY_LEN  = LVL_W'(PAYLOAD_WORDS);
    localparam logic [LVL_W-1:0] PAY_LAST = LVL_W'(PAYLOAD_WORDS - 1);
    localparam logic [31:0]      PKT_SIZE = 32'(PAYLOAD_WORDS * 4 + 4);
    localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

    state_t              state_q,    state_d;
    logic [3:0]          cur_ch_q,   cur_ch_d;
    logic [1:0]          hdr_cnt_q,  hdr_cnt_d;
    logic [LVL_W-1:0]    pay_cnt_q,  pay_cnt_d;
    logic [23:0]         ival_cnt_q, ival_cnt_d;
    logic [23:0]         interval_q, interval_d;
    logic [NUM_CH-1:0]   en_mask_q,  en_mask_d;
    logic [31:0]         dst_ip_q,   dst_ip_d;
    logic [31:0]         pkt_cnt_q,  pkt_cnt_d;
    logic                w_enable_q, w_enable_d;
    logic [31:0]         w_data_q,   w_data_d;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   cur_onehot;
    logic [27:0]         cur_tag;
    logic [31:0]         cur_data;
    logic                interval_ok;

    assign interval_ok = (ival_cnt_q >= interval_q);

    // Per-channel eligibility and head-of-line selection for the current
    // channel. The level compare is combinational so a level that reaches
    // PAYLOAD_WORDS in the ARB cycle itself still counts.
    // NOTE: every signal assigned in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        eligible   = '0;
        cur_onehot = '0;
        cur_tag    = '0;
        cur_data   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = en_mask_q[c] && (ch_level[c*LVL_W +: LVL_W] >= PAY_LEN);
            if (cur_ch_q == 4'(c)) begin
                cur_onehot[c] = 1'b1;
                cur_tag       = ch_tag[c*28 +: 28];
                cur_data      = ch_data[c*32 +: 32];
            end
        end
    end

    always_comb begin
        int   idx;
        logic found;

        idx        = 0;
        found      = 1'b0;
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        hdr_cnt_d  = hdr_cnt_q;
        pay_cnt_d  = pay_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        interval_d = interval_q;
        en_mask_d  = en_mask_q;
        dst_ip_d   = dst_ip_q;
        ival_cnt_d = (ival_cnt_q < interval_q) ? ival_cnt_q + 24'd1 : ival_cnt_q;
        w_enable_d = 1'b0;
        w_data_d   = '0;
        w_req      = 1'b0;
        ch_rd      = '0;
        ch_tag_rd  = '0;

        // Register updates land on the next edge, so an ARB decision this
        // cycle always uses the old mask.
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    interval_d = cfg_data[23:0];
                2'd1:    en_mask_d  = cfg_data[NUM_CH-1:0];
                2'd2:    dst_ip_d   = cfg_data;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (interval_ok) state_d = ARB;
            end

            ARB: begin
                // Round-robin: start one past the last served channel, wrap.
                state_d = IDLE;
                for (int i = 1; i <= NUM_CH; i++) begin
                    idx = int'(cur_ch_q) + i;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                    if (!found && eligible[idx]) begin
                        found    = 1'b1;
                        cur_ch_d = 4'(idx);
                        state_d  = REQ;
                    end
                end
            end

            REQ: begin
                w_req = 1'b1;
                if (w_ack) begin
                    state_d   = HDR;
                    hdr_cnt_d = '0;
                end
            end

            HDR: begin
                w_enable_d = 1'b1;
                case (hdr_cnt_q)
                    2'd0:    w_data_d = dst_ip_q;
                    2'd1:    w_data_d = SRC_IP;
                    2'd2:    w_data_d = PORTS;
                    default: w_data_d = PKT_SIZE;
                endcase
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd3) state_d = INFO;
            end

            INFO: begin
                w_enable_d = 1'b1;
                w_data_d   = {cur_ch_q, cur_tag};
                ch_tag_rd  = cur_onehot;
                pay_cnt_d  = '0;
                state_d    = PAY;
            end

            PAY: begin
                w_enable_d = 1'b1;
                w_data_d   = cur_data;
                ch_rd      = cur_onehot;
                pay_cnt_d  = pay_cnt_q + 1'b1;
                if (pay_cnt_q == PAY_LAST) begin
                    state_d    = IDLE;
                    pkt_cnt_d  = pkt_cnt_q + 32'd1;
                    ival_cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase

        // A reset aborts the packet at once: no pop and no request may leak
        // out in the cycle the reset is applied.
        if (rst) begin
            ch_rd     = '0;
            ch_tag_rd = '0;
            w_req     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= CH_LAST;
            hdr_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            ival_cnt_q <= '0;
            interval_q <= '0;
            en_mask_q  <= '1;
            dst_ip_q   <= DST_IP_RST;
            pkt_cnt_q  <= '0;
            w_enable_q <= 1'b0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            hdr_cnt_q  <= hdr_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            ival_cnt_q <= ival_cnt_d;
            interval_q <= interval_d;
            en_mask_q  <= en_mask_d;
            dst_ip_q   <= dst_ip_d;
            pkt_cnt_q  <= pkt_cnt_d;
            w_enable_q <= w_enable_d;
            w_data_q   <= w_data_d;
        end
    end

    assign w_enable = w_enable_q;
    assign w_data   = w_data_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_udp_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_udp_stream_tx
//
// Directed bench for udp_stream_tx with NUM_CH=2, PAYLOAD_WORDS=4. Each channel
// is a small FWFT model: head word = (ch<<16) + pops + 1, tag = base + tag pops
// (ch0 base 0x123, ch1 base 0x456). A monitor records every written word, the
// INFO words, the length of each w_enable run and the idle gap before it.
// -----------------------------------------------------------------------------
module tb_udp_stream_tx;

    localparam int NUM_CH = 2;
    localparam int PW     = 4;
    localparam int LVL_W  = 12;

    logic                    clk;
    logic                    rst;
    logic                    cfg_we;
    logic [1:0]              cfg_addr;
    logic [31:0]             cfg_data;
    logic [NUM_CH*LVL_W-1:0] ch_level;
    logic [NUM_CH*32-1:0]    ch_data;
    logic [NUM_CH*28-1:0]    ch_tag;
    logic [NUM_CH-1:0]       ch_rd;
    logic [NUM_CH-1:0]       ch_tag_rd;
    logic                    w_req;
    logic                    w_ack;
    logic                    w_enable;
    logic [31:0]             w_data;
    logic [31:0]             pkt_cnt;
    logic [3:0]              cur_ch;

    udp_stream_tx #(
        .NUM_CH(NUM_CH),
        .PAYLOAD_WORDS(PW),
        .LVL_W(LVL_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .ch_level(ch_level),
        .ch_data(ch_data),
        .ch_tag(ch_tag),
        .ch_rd(ch_rd),
        .ch_tag_rd(ch_tag_rd),
        .w_req(w_req),
        .w_ack(w_ack),
        .w_enable(w_enable),
        .w_data(w_data),
        .pkt_cnt(pkt_cnt),
        .cur_ch(cur_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models
    logic [11:0] lvl0, lvl1;
    logic [31:0] rd_cnt0, rd_cnt1;
    logic [27:0] tag_cnt0, tag_cnt1;

    assign ch_level = {lvl1, lvl0};
    assign ch_data  = {32'h00010000 + rd_cnt1 + 32'd1, rd_cnt0 + 32'd1};
    assign ch_tag   = {28'h456 + tag_cnt1, 28'h123 + tag_cnt0};

    always @(posedge clk) begin
        if (rst) begin
            rd_cnt0  <= '0;
            rd_cnt1  <= '0;
            tag_cnt0 <= '0;
            tag_cnt1 <= '0;
        end else begin
            if (ch_rd[0])     rd_cnt0  <= rd_cnt0 + 32'd1;
            if (ch_rd[1])     rd_cnt1  <= rd_cnt1 + 32'd1;
            if (ch_tag_rd[0]) tag_cnt0 <= tag_cnt0 + 28'd1;
            if (ch_tag_rd[1]) tag_cnt1 <= tag_cnt1 + 28'd1;
        end
    end

    // Output monitor, sampling 2 time units after each rising edge
    logic [31:0] words[$];
    logic [31:0] infos[$];
    int          runs[$];
    int          gaps[$];
    int          run_len = 0;
    int          gap_len = 0;
    logic        prev_en = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (w_enable === 1'b1) begin
            if (!prev_en) begin
                gaps.push_back(gap_len);
                gap_len = 0;
                run_len = 0;
            end
            if (run_len == 4) infos.push_back(w_data);
            words.push_back(w_data);
            run_len++;
            prev_en = 1'b1;
        end else begin
            if (prev_en) runs.push_back(run_len);
            gap_len++;
            prev_en = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_mon();
        words.delete();
        infos.delete();
        runs.delete();
        gaps.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_pkt(input logic [31:0] target, input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pkt_cnt == target) break;
        end
        check(tag, pkt_cnt, target);
    endtask

    logic [31:0] hdr_exp [4];
    logic [31:0] pkt1_exp[9];
    int          bad;
    logic        seen;

    initial begin
        hdr_exp  = '{32'h0a000003, 32'h0a000001, 32'h40004000, 32'h00000014};
        pkt1_exp = '{32'h0a000003, 32'h0a000001, 32'h40004000, 32'h00000014,
                     32'h00000123, 32'd1, 32'd2, 32'd3, 32'd4};
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        w_ack = 1'b1; lvl0 = '0; lvl1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();

        // Reset state
        check("rst_w_req",     32'(w_req),     32'd0);
        check("rst_w_enable",  32'(w_enable),  32'd0);
        check("rst_w_data",    w_data,         32'd0);
        check("rst_ch_rd",     32'(ch_rd),     32'd0);
        check("rst_ch_tag_rd", 32'(ch_tag_rd), 32'd0);
        check("rst_pkt_cnt",   pkt_cnt,        32'd0);
        check("rst_cur_ch",    32'(cur_ch),    32'd1);

        // Single channel packet
        lvl0 = 12'd4;
        wait_pkt(32'd1, "t1_pkt_cnt");
        lvl0 = '0;
        repeat (3) @(negedge clk);
        check("t1_nwords", 32'(words.size()), 32'd9);
        for (int i = 0; i < 9; i++) check($sformatf("t1_word%0d", i), words[i], pkt1_exp[i]);
        check("t1_run",     32'(runs[0]), 32'd9);
        check("t1_cur_ch",  32'(cur_ch),  32'd0);
        check("t1_pops0",   rd_cnt0,      32'd4);
        check("t1_tagpop0", 32'(tag_cnt0), 32'd1);
        check("t1_pops1",   rd_cnt1,      32'd0);

        // Two channels, interval 0: ch0, ch1, ch0 back to back
        do_reset();
        lvl0 = 12'd4; lvl1 = 12'd4;
        wait_pkt(32'd3, "t2_pkt_cnt");
        lvl0 = '0; lvl1 = '0;
        repeat (3) @(negedge clk);
        check("t2_nwords", 32'(words.size()), 32'd27);
        check("t2_info0", infos[0], 32'h00000123);
        check("t2_info1", infos[1], 32'h10000456);
        check("t2_info2", infos[2], 32'h00000124);
        for (int p = 0; p < 3; p++) begin
            for (int h = 0; h < 4; h++)
                check($sformatf("t2_p%0d_hdr%0d", p, h), words[p*9+h], hdr_exp[h]);
            check($sformatf("t2_p%0d_run", p), 32'(runs[p]), 32'd9);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_p0_pay%0d", i), words[5+i],  32'd1 + 32'(i));
            check($sformatf("t2_p1_pay%0d", i), words[14+i], 32'h00010001 + 32'(i));
            check($sformatf("t2_p2_pay%0d", i), words[23+i], 32'd5 + 32'(i));
        end
        check("t2_gap1", 32'(gaps[1]), 32'd3);
        check("t2_gap2", 32'(gaps[2]), 32'd3);

        // Interval 100: last PAY -> IDLE(101 cycles) -> ARB -> REQ -> HDR,
        // so 103 idle output cycles between packets.
        cfg_write(2'd0, 32'd100);
        lvl0 = 12'd4; lvl1 = 12'd4;
        wait_pkt(32'd5, "t3_pkt_cnt");
        lvl0 = '0; lvl1 = '0;
        repeat (3) @(negedge clk);
        check("t3_gap",  32'(gaps[gaps.size()-1]), 32'd103);
        check("t3_run",  32'(runs[runs.size()-1]), 32'd9);
        check("t3_info", infos[infos.size()-1] & 32'hf0000000, 32'h00000000);

        // Disable ch0 while its packet is in flight
        do_reset();
        lvl0 = 12'd4; lvl1 = 12'd4;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (w_enable) seen = 1'b1;
        end
        check("t4_inflight", 32'(seen), 32'd1);
        check("t4_cur_ch0",  32'(cur_ch), 32'd0);
        cfg_write(2'd1, 32'h2);
        wait_pkt(32'd3, "t4_pkt_cnt");
        lvl0 = '0; lvl1 = '0;
        repeat (3) @(negedge clk);
        check("t4_ninfo", 32'(infos.size()), 32'd3);
        check("t4_info0", infos[0] & 32'hf0000000, 32'h00000000);
        check("t4_info1", infos[1] & 32'hf0000000, 32'h10000000);
        check("t4_info2", infos[2] & 32'hf0000000, 32'h10000000);
        check("t4_run0",  32'(runs[0]), 32'd9);

        // w_ack held low, new destination IP
        do_reset();
        w_ack = 1'b0;
        cfg_write(2'd2, 32'hc0a80005);
        lvl0 = 12'd4;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (w_req) seen = 1'b1;
        end
        check("t5_req_seen", 32'(seen), 32'd1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_req !== 1'b1 || ch_rd !== '0 || ch_tag_rd !== '0 || w_enable !== 1'b0) bad++;
        end
        check("t5_wait_viol", 32'(bad), 32'd0);
        check("t5_no_pops",   rd_cnt0,  32'd0);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        check("t5_req_drop", 32'(w_req),    32'd0);
        @(negedge clk);
        check("t5_hdr_en",   32'(w_enable), 32'd1);
        check("t5_hdr_dst",  w_data,        32'hc0a80005);
        wait_pkt(32'd1, "t5_pkt_cnt");
        lvl0 = '0;

        // Reset at the 3rd PAY word
        do_reset();
        w_ack = 1'b1;
        lvl0 = 12'd4;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ch_rd[0] && rd_cnt0 == 32'd2) seen = 1'b1;
        end
        check("t6_third_pay", 32'(seen), 32'd1);
        rst = 1'b1;
        lvl0 = '0;
        @(negedge clk);
        check("t6_ch_rd",   32'(ch_rd),  32'd0);
        check("t6_w_req",   32'(w_req),  32'd0);
        check("t6_pkt_cnt", pkt_cnt,     32'd0);
        check("t6_cur_ch",  32'(cur_ch), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_w_enable", 32'(w_enable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
